// File: rtl/ghash_ctrl.sv
// GHASH controller: bit-serial GF(2^128) multiply of (X ^ Y) by H, with writeback
// to an external accumulator and a tag handshake on the final block of a message.
module ghash_ctrl #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] h_key,
    input  logic             h_load,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [WIDTH-1:0] blk_data,
    input  logic             blk_last,
    output logic             tag_valid,
    input  logic             tag_ready,
    output logic [WIDTH-1:0] tag_out,
    output logic             ac_en,
    output logic             clr_ac,
    output logic [WIDTH-1:0] ac_data_in,
    input  logic [WIDTH-1:0] ac_data_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] R_POLY = {8'hE1, {(WIDTH-8){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, WB, TAG} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   h_q, h_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic [WIDTH-1:0]   v_q, v_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               accept_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            z_q     <= '0;
            v_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            z_q     <= z_d;
            v_q     <= v_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        z_d        = z_q;
        v_d        = v_q;
        s_d        = s_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        blk_ready  = 1'b0;
        tag_valid  = 1'b0;
        tag_out    = '0;
        ac_en      = 1'b0;
        clr_ac     = 1'b0;
        ac_data_in = '0;
        accept_c   = 1'b0;

        case (state_q)
            IDLE: begin
                blk_ready = ~h_load & ~clr;
                accept_c  = blk_valid & ~h_load & ~clr;
                if (h_load) begin
                    h_d = h_key;
                end
                if (accept_c) begin
                    z_d     = '0;
                    v_d     = h_q;
                    s_d     = blk_data ^ ac_data_out;
                    last_d  = blk_last;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            // S is shifted left so its MSB is always the current multiplier bit.
            MUL: begin
                if (s_q[WIDTH-1]) begin
                    z_d = z_q ^ v_q;
                end
                v_d   = (v_q >> 1) ^ (v_q[0] ? R_POLY : '0);
                s_d   = s_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = WB;
                end
            end
            WB: begin
                ac_en      = 1'b1;
                ac_data_in = z_q;
                state_d    = last_q ? TAG : IDLE;
            end
            TAG: begin
                tag_valid = 1'b1;
                tag_out   = ac_data_out;
                if (tag_ready) begin
                    clr_ac  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Soft clear abandons any work in flight but keeps the loaded subkey.
        if (clr) begin
            blk_ready  = 1'b0;
            tag_valid  = 1'b0;
            tag_out    = '0;
            ac_en      = 1'b0;
            ac_data_in = '0;
            clr_ac     = 1'b1;
            state_d    = IDLE;
        end
    end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Bench for ghash_ctrl: directed GCM vectors plus random messages checked against a
// carry-less-multiply-and-reduce GHASH model and an accumulator model.
module tb_ghash_ctrl;

    logic         clk;
    logic         rst;
    logic         clr;
    logic [127:0] h_key;
    logic         h_load;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic         blk_last;
    logic         tag_valid;
    logic         tag_ready;
    logic [127:0] tag_out;
    logic         ac_en;
    logic         clr_ac;
    logic [127:0] ac_data_in;
    logic [127:0] acc;

    int checks = 0;
    int errors = 0;
    int ac_en_cnt = 0;
    int clr_cnt = 0;
    int both_seen = 0;

    logic [127:0] h_m;
    logic [127:0] y_m;

    ghash_ctrl #(.WIDTH(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .h_key      (h_key),
        .h_load     (h_load),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_last   (blk_last),
        .tag_valid  (tag_valid),
        .tag_ready  (tag_ready),
        .tag_out    (tag_out),
        .ac_en      (ac_en),
        .clr_ac     (clr_ac),
        .ac_data_in (ac_data_in),
        .ac_data_out(acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External accumulator, cleared by the system reset.
    always @(posedge clk or posedge rst) begin
        if (rst)         acc <= '0;
        else if (ac_en)  acc <= ac_data_in;
        else if (clr_ac) acc <= '0;
    end

    always @(posedge clk) begin
        if (ac_en)          ac_en_cnt <= ac_en_cnt + 1;
        if (clr_ac)         clr_cnt   <= clr_cnt + 1;
        if (ac_en & clr_ac) both_seen <= both_seen + 1;
    end

    function automatic logic [127:0] rev128(input logic [127:0] a);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = a[127-i];
        return r;
    endfunction

    // GCM bit order is reflected; multiply as polynomials, reduce by x^128+x^7+x^2+x+1.
    function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] ar;
        logic [127:0] br;
        logic [254:0] p;
        ar = rev128(a);
        br = rev128(b);
        p  = '0;
        for (int i = 0; i < 128; i++)
            if (br[i]) p = p ^ (255'(ar) << i);
        for (int i = 254; i >= 128; i--)
            if (p[i]) begin
                p[i] = 1'b0;
                p    = p ^ (255'(8'h87) << (i - 128));
            end
        return rev128(p[127:0]);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_h(input logic [127:0] h, input logic with_valid);
        h_key     = h;
        h_load    = 1'b1;
        blk_valid = with_valid;
        blk_data  = rnd128();
        #1;
        chk("blk_ready_during_hload", 128'(blk_ready), 128'(0));
        cyc();
        h_load = 1'b0;
        h_m    = h;
    endtask

    // Offers one block in the current IDLE cycle and returns in cycle 130 after accept.
    task automatic send_block(input logic [127:0] x, input logic last);
        logic [127:0] exp;
        int c;
        blk_data  = x;
        blk_last  = last;
        blk_valid = 1'b1;
        #1;
        chk("blk_ready_idle", 128'(blk_ready), 128'(1));
        cyc();
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        exp = gf_mul(y_m ^ x, h_m);
        y_m = exp;
        c = 1;
        while (!ac_en && c < 300) begin
            chk("no_tag_during_mul", 128'(tag_valid), 128'(0));
            cyc();
            c++;
        end
        chk("wb_cycle", 128'(c), 128'(129));
        chk("ac_data_in", ac_data_in, exp);
        chk("no_clr_in_wb", 128'(clr_ac), 128'(0));
        cyc();
        if (last) begin
            chk("tag_valid_130", 128'(tag_valid), 128'(1));
            chk("tag_out", tag_out, exp);
        end else begin
            chk("no_tag_nonlast", 128'(tag_valid), 128'(0));
            chk("blk_ready_130", 128'(blk_ready), 128'(1));
        end
    endtask

    task automatic handshake();
        tag_ready = 1'b1;
        #1;
        chk("clr_ac_handshake", 128'(clr_ac), 128'(1));
        chk("ac_en_handshake", 128'(ac_en), 128'(0));
        cyc();
        tag_ready = 1'b0;
        y_m = '0;
        #1;
        chk("blk_ready_after_tag", 128'(blk_ready), 128'(1));
        chk("tag_valid_after_tag", 128'(tag_valid), 128'(0));
        chk("acc_cleared", acc, 128'(0));
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] t_hold;
        int n;
        int nb;
        rst = 1'b1; clr = 1'b0; h_key = '0; h_load = 1'b0;
        blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0; tag_ready = 1'b0;
        h_m = '0; y_m = '0;
        #2;
        chk("rst_tag_valid", 128'(tag_valid), 128'(0));
        chk("rst_ac_en", 128'(ac_en), 128'(0));
        chk("rst_clr_ac", 128'(clr_ac), 128'(0));
        chk("rst_ac_data_in", ac_data_in, 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("blk_ready_after_rst", 128'(blk_ready), 128'(1));

        // Identity key; block offered together with h_load must wait one cycle.
        load_h(128'h80000000_00000000_00000000_00000000, 1'b1);
        send_block(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1);
        chk("identity_const", tag_out, 128'h0123456789ABCDEF_FEDCBA9876543210);
        handshake();

        load_h(128'h66E94BD4EF8A2C3B_884CFA59CA342B2E, 1'b0);
        send_block(128'h80000000_00000000_00000000_00000000, 1'b1);
        chk("commute_const", tag_out, 128'h66E94BD4EF8A2C3B_884CFA59CA342B2E);
        handshake();

        load_h(128'h80000000_00000000_00000000_00000000, 1'b0);
        send_block(128'hFF000000_00000000_00000000_00000000, 1'b0);
        send_block(128'h00FF0000_00000000_00000000_00000000, 1'b1);
        chk("two_block_const", tag_out, 128'hFFFF0000_00000000_00000000_00000000);
        handshake();

        // Tag backpressure.
        load_h(rnd128(), 1'b0);
        send_block(rnd128(), 1'b1);
        t_hold = tag_out;
        for (int i = 0; i < 10; i++) begin
            chk("bp_tag_valid", 128'(tag_valid), 128'(1));
            chk("bp_tag_stable", tag_out, t_hold);
            chk("bp_no_clr", 128'(clr_ac), 128'(0));
            cyc();
        end
        handshake();

        // Random multi-block messages.
        for (int m = 0; m < 6; m++) begin
            load_h(rnd128(), 1'b0);
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) send_block(rnd128(), b == nb - 1);
            handshake();
        end

        // Soft clear at MUL cycle 60; H must survive.
        load_h(rnd128(), 1'b0);
        x = rnd128();
        blk_data = x; blk_last = 1'b1; blk_valid = 1'b1;
        cyc();
        blk_valid = 1'b0; blk_last = 1'b0;
        repeat (59) cyc();
        n = ac_en_cnt;
        clr = 1'b1;
        #1;
        chk("abort_clr_ac", 128'(clr_ac), 128'(1));
        chk("abort_ac_en", 128'(ac_en), 128'(0));
        chk("abort_blk_ready", 128'(blk_ready), 128'(0));
        cyc();
        clr = 1'b0;
        y_m = '0;
        #1;
        chk("abort_idle", 128'(blk_ready), 128'(1));
        repeat (80) cyc();
        chk("abort_no_wb", 128'(ac_en_cnt), 128'(n));
        send_block(rnd128(), 1'b1);
        handshake();

        // Reset while in TAG: tag drops at once and no clear pulse is issued.
        load_h(rnd128(), 1'b0);
        send_block(rnd128(), 1'b1);
        n = clr_cnt;
        rst = 1'b1;
        #1;
        chk("rst_tag_drop", 128'(tag_valid), 128'(0));
        chk("rst_tag_no_clr", 128'(clr_ac), 128'(0));
        cyc();
        rst = 1'b0;
        y_m = '0;
        h_m = '0;
        #1;
        chk("rst_tag_no_clr_pulse", 128'(clr_cnt), 128'(n));
        chk("rst_tag_idle", 128'(blk_ready), 128'(1));
        send_block(rnd128(), 1'b1);
        handshake();

        chk("never_en_and_clr", 128'(both_seen), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
